// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// dense_layer_sequencer: one fully-connected layer time-multiplexed onto a single signed MAC.
// Rev 1.0 - Q8.8 feature stream in, per-neuron Q8.8 results out, valid/ready on both sides.
module dense_layer_sequencer #(
  parameter int INPUT_SIZE   = 32,
  parameter int OUTPUT_SIZE  = 8,
  parameter int WEIGHT_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int FRAC_BITS    = 8,
  localparam int W_ADDR_W    = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1,
  localparam int IDX_W       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WEIGHT_WIDTH-1:0] in_data,
  output logic                    w_en,
  output logic [W_ADDR_W-1:0]     w_addr,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  output logic [IDX_W-1:0]        b_addr,
  input  logic [WEIGHT_WIDTH-1:0] b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WEIGHT_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int K_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [K_W-1:0]      K_LAST   = K_W'(INPUT_SIZE - 1);
  localparam logic [K_W-1:0]      K_ONE    = K_W'(1);
  localparam logic [IDX_W-1:0]    N_LAST   = IDX_W'(OUTPUT_SIZE - 1);
  localparam logic [IDX_W-1:0]    N_ONE    = IDX_W'(1);
  localparam logic [W_ADDR_W-1:0] ADDR_ONE = W_ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MAC    = 3'd2,
    S_FINISH = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t                         state_q;
  logic [K_W-1:0]                 k_q;
  logic [IDX_W-1:0]               neuron_q;
  logic [W_ADDR_W-1:0]            w_addr_q;
  logic                           w_en_q;
  logic                           out_valid_q;
  logic [WEIGHT_WIDTH-1:0]        out_data_q;
  logic [IDX_W-1:0]               out_idx_q;
  logic [WEIGHT_WIDTH-1:0]        feat_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic [WEIGHT_WIDTH-1:0]        buf_q [INPUT_SIZE];

  logic                           in_hs;
  logic                           out_hs;
  logic                           last_k;
  logic                           last_neuron;
  logic [K_W-1:0]                 wr_idx;
  logic signed [2*WEIGHT_WIDTH-1:0] feat_ext;
  logic signed [2*WEIGHT_WIDTH-1:0] wd_ext;
  logic signed [2*WEIGHT_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc_f;

  assign in_ready    = rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid_q && out_ready;
  assign last_k      = (k_q == K_LAST);
  assign last_neuron = (neuron_q == N_LAST);
  assign wr_idx      = (state_q == S_IDLE) ? '0 : k_q;

  // feat_q lags the weight address by one cycle, matching the ROM read latency.
  assign feat_ext = {{WEIGHT_WIDTH{feat_q[WEIGHT_WIDTH-1]}}, feat_q};
  assign wd_ext   = {{WEIGHT_WIDTH{w_data[WEIGHT_WIDTH-1]}}, w_data};
  assign prod     = feat_ext * wd_ext;
  assign prod_ext = ACC_WIDTH'(prod);
  assign acc_f    = acc_q + prod_ext;

  // Feature storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_q[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      neuron_q    <= '0;
      w_addr_q    <= '0;
      w_en_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      feat_q      <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_hs) begin
            neuron_q <= '0;
            w_addr_q <= '0;
            if (INPUT_SIZE == 1) begin
              state_q <= S_MAC;
              w_en_q  <= 1'b1;
              k_q     <= '0;
            end else begin
              state_q <= S_LOAD;
              k_q     <= K_ONE;
            end
          end
        end
        S_LOAD: begin
          if (in_hs) begin
            if (last_k) begin
              state_q <= S_MAC;
              w_en_q  <= 1'b1;
              k_q     <= '0;
            end else begin
              k_q <= k_q + K_ONE;
            end
          end
        end
        S_MAC: begin
          feat_q   <= buf_q[k_q];
          acc_q    <= (k_q == '0) ? '0 : acc_f;
          w_addr_q <= w_addr_q + ADDR_ONE;
          if (last_k) begin
            state_q <= S_FINISH;
            w_en_q  <= 1'b0;
            k_q     <= '0;
          end else begin
            k_q <= k_q + K_ONE;
          end
        end
        S_FINISH: begin
          out_data_q  <= acc_f[WEIGHT_WIDTH+FRAC_BITS-1:FRAC_BITS] + b_data;
          out_idx_q   <= neuron_q;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_neuron) begin
              state_q <= S_IDLE;
            end else begin
              neuron_q <= neuron_q + N_ONE;
              w_en_q   <= 1'b1;
              state_q  <= S_MAC;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_en      = w_en_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = neuron_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = out_hs && last_neuron;

endmodule
`default_nettype wire
